// File: rtl/cnn_conv_layer.sv
// rtl/cnn_conv_layer.sv - streaming 4x4 depthwise convolution over one 32-column, 4-row, 3-channel strip
module cnn_conv_layer #(
  parameter int           WIDTH   = 32,
  parameter logic [383:0] WEIGHTS = 384'h0
) (
  input  logic                       clk,
  input  logic                       RESET,
  input  logic                       start_rd,
  input  logic [23:0]                in0_q,
  input  logic [23:0]                in1_q,
  input  logic [23:0]                in2_q,
  input  logic [23:0]                in3_q,
  output logic                       in0_rden,
  output logic                       in1_rden,
  output logic                       in2_rden,
  output logic                       in3_rden,
  output logic [$clog2(WIDTH)-1:0]   in_addr,
  output logic [62:0]                result,
  output logic                       fin_rd,
  output logic                       de_out
);

  localparam int AW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic            rden_q;
  logic            fin_q;

  // BRAM data of the previous cycle's read is valid while cap_vld_q is high
  logic            cap_vld_q;
  logic [AW:0]     col_cnt_q;
  logic            win_vld_q;
  logic            prd_vld_q;
  logic            de_q;
  logic [62:0]     result_q;

  logic [7:0]          pix_q  [4][3][4];
  logic signed [16:0]  prod_q [3][16];
  logic signed [20:0]  sum_d  [3];
  logic [23:0]         row_in [4];

  assign row_in[0] = in0_q;
  assign row_in[1] = in1_q;
  assign row_in[2] = in2_q;
  assign row_in[3] = in3_q;

  assign in0_rden = rden_q;
  assign in1_rden = rden_q;
  assign in2_rden = rden_q;
  assign in3_rden = rden_q;
  assign in_addr  = addr_q;
  assign fin_rd   = fin_q;
  assign de_out   = de_q;
  assign result   = result_q;

  // Tap for channel c, row r, column offset k (k=0 is the oldest column)
  function automatic logic signed [16:0] tap17(input int c, input int r, input int k);
    logic [7:0] t;
    t = WEIGHTS[((c * 16) + (r * 4) + k) * 8 +: 8];
    return {{9{t[7]}}, t};
  endfunction

  // Strip sequencer: one read per column, then hold DONE until the request drops
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rden_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_rd) begin
            state_q <= READ;
            addr_q  <= '0;
            rden_q  <= 1'b1;
          end
        end
        READ: begin
          if (addr_q == AW'(WIDTH - 1)) begin
            state_q <= DONE;
            addr_q  <= '0;
            rden_q  <= 1'b0;
            fin_q   <= 1'b1;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        DONE: begin
          if (!start_rd) begin
            state_q <= IDLE;
            fin_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          addr_q  <= '0;
          rden_q  <= 1'b0;
          fin_q   <= 1'b0;
        end
      endcase
    end
  end

  // Track which cycles carry read data and when a full 4-column window is present
  always_ff @(posedge clk) begin
    if (!RESET) begin
      cap_vld_q <= 1'b0;
      col_cnt_q <= '0;
      win_vld_q <= 1'b0;
    end else begin
      cap_vld_q <= rden_q;
      win_vld_q <= cap_vld_q && (col_cnt_q >= (AW + 1)'(3));
      if (cap_vld_q) begin
        col_cnt_q <= col_cnt_q + 1'b1;
      end else if (state_q == IDLE) begin
        col_cnt_q <= '0;
      end
    end
  end

  // Per-row, per-channel 4-deep column shift registers; newest column enters at k=3
  always_ff @(posedge clk) begin
    if (!RESET) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 3; c++) begin
          for (int k = 0; k < 4; k++) begin
            pix_q[r][c][k] <= '0;
          end
        end
      end
    end else if (cap_vld_q) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 3; c++) begin
          for (int k = 0; k < 3; k++) begin
            pix_q[r][c][k] <= pix_q[r][c][k + 1];
          end
          pix_q[r][c][3] <= row_in[r][c * 8 +: 8];
        end
      end
    end
  end

  // Stage 1: 48 unsigned-pixel by signed-tap products
  always_ff @(posedge clk) begin
    if (!RESET) begin
      prd_vld_q <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i < 16; i++) begin
          prod_q[c][i] <= '0;
        end
      end
    end else begin
      prd_vld_q <= win_vld_q;
      if (win_vld_q) begin
        for (int c = 0; c < 3; c++) begin
          for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
              prod_q[c][(r * 4) + k] <= $signed({9'b0, pix_q[r][c][k]}) * tap17(c, r, k);
            end
          end
        end
      end
    end
  end

  // Stage 2 adder tree input: 16-term signed sum per channel, wraps at 21 bits
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sum_d[c] = '0;
      for (int i = 0; i < 16; i++) begin
        sum_d[c] = sum_d[c] + {{4{prod_q[c][i][16]}}, prod_q[c][i]};
      end
    end
  end

  // Stage 2: register the packed result; it holds between strobes
  always_ff @(posedge clk) begin
    if (!RESET) begin
      de_q     <= 1'b0;
      result_q <= '0;
    end else begin
      de_q <= prd_vld_q;
      if (prd_vld_q) begin
        result_q <= {sum_d[2], sum_d[1], sum_d[0]};
      end
    end
  end

endmodule

// File: tb/tb_cnn_conv_layer.sv
// tb/tb_cnn_conv_layer.sv - scoreboard bench for cnn_conv_layer across four weight sets
module tb_cnn_conv_layer;

  logic        clk = 1'b0;
  logic        RESET;
  logic        start_rd;
  int          mode;

  logic [23:0] bq   [4];
  logic        r0   [4];
  logic        r1   [4];
  logic        r2   [4];
  logic        r3   [4];
  logic [4:0]  addr [4];
  logic [62:0] res  [4];
  logic        fin  [4];
  logic        de   [4];

  logic [62:0] exp_q [4][$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  always #5 clk = ~clk;

  // g=0 all taps +1, g=1 all -128, g=2 all +127, g=3 only tap(0,0,0)=+1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam logic [383:0] WG = (g == 0) ? {48{8'h01}} :
                                  (g == 1) ? {48{8'h80}} :
                                  (g == 2) ? {48{8'h7f}} : 384'h1;
    cnn_conv_layer #(.WIDTH(32), .WEIGHTS(WG)) u_dut (
      .clk      (clk),
      .RESET    (RESET),
      .start_rd (start_rd),
      .in0_q    (bq[g]),
      .in1_q    (bq[g]),
      .in2_q    (bq[g]),
      .in3_q    (bq[g]),
      .in0_rden (r0[g]),
      .in1_rden (r1[g]),
      .in2_rden (r2[g]),
      .in3_rden (r3[g]),
      .in_addr  (addr[g]),
      .result   (res[g]),
      .fin_rd   (fin[g]),
      .de_out   (de[g])
    );
  end

  function automatic logic [23:0] pix_word(input int m, input logic [4:0] a);
    case (m)
      1:       return 24'h010101;
      2:       return 24'hffffff;
      3:       return {19'h0, a};
      default: return 24'h000000;
    endcase
  endfunction

  // One-cycle-latency BRAM model; junk on the bus when not read
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      bq[g] <= r0[g] ? pix_word(mode, addr[g]) : 24'ha5a5a5;
    end
  end

  // Hand-derived expectations: s = window pixel sum per channel, p = oldest row0 pixel
  function automatic logic [62:0] exp_res(input int g, input int m, input int j);
    int s [3];
    int v;
    int p0;
    logic [62:0] r;
    p0 = 0;
    for (int c = 0; c < 3; c++) s[c] = 0;
    case (m)
      1: begin for (int c = 0; c < 3; c++) s[c] = 16;   p0 = 1;   end
      2: begin for (int c = 0; c < 3; c++) s[c] = 4080; p0 = 255; end
      3: begin s[0] = 16 * j + 24; p0 = j; end
      default: ;
    endcase
    r = '0;
    for (int c = 0; c < 3; c++) begin
      case (g)
        0:       v = s[c];
        1:       v = -128 * s[c];
        2:       v = 127 * s[c];
        default: v = (c == 0) ? p0 : 0;
      endcase
      r[c * 21 +: 21] = v[20:0];
    end
    return r;
  endfunction

  task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s dut%0d actual=%h required=%h", name, g, act, req);
  endtask

  // Monitor: pop and compare on every result strobe
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (de[g] === 1'b1) begin
        if (exp_q[g].size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_de dut%0d actual=%h required=no_output", g, res[g]);
        end else begin
          check("result", g, {1'b0, res[g]}, {1'b0, exp_q[g].pop_front()});
        end
      end
    end
  end

  task automatic run_strip(input int m, input bit hold, input int abort_at);
    mode = m;
    for (int j = 0; j < 29; j++)
      for (int g = 0; g < 4; g++) exp_q[g].push_back(exp_res(g, m, j));
    @(negedge clk);
    start_rd = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (c == 0) begin
          check("rden_c0", g, {60'h0, r0[g], r1[g], r2[g], r3[g]}, 64'hf);
          check("addr_c0", g, 64'(addr[g]), 64'd0);
        end
        if (c == 6) check("de_c6", g, 64'(de[g]), 64'd0);
        if (c == 7) check("de_c7", g, 64'(de[g]), 64'd1);
        if (abort_at < 0) begin
          if (c == 31) check("addr_c31", g, 64'(addr[g]), 64'd31);
          if (c == 31) check("fin_c31", g, 64'(fin[g]), 64'd0);
          if (c == 32) check("fin_c32", g, 64'(fin[g]), 64'd1);
          if (c == 32) check("rden_c32", g, 64'(r0[g]), 64'd0);
          if (c == 33 && !hold) check("fin_c33", g, 64'(fin[g]), 64'd0);
          if (c == 35) check("de_c35", g, 64'(de[g]), 64'd1);
          if (c == 36) check("de_c36", g, 64'(de[g]), 64'd0);
          if (c == 40) check("queue_empty", g, 64'(exp_q[g].size()), 64'd0);
          if (c == 40 && hold) check("hold_fin", g, 64'(fin[g]), 64'd1);
          if (c == 40 && hold) check("hold_rden", g, 64'(r0[g]), 64'd0);
        end else if (c == abort_at + 1) begin
          check("rst_de", g, 64'(de[g]), 64'd0);
          check("rst_result", g, 64'(res[g]), 64'd0);
          check("rst_fin", g, 64'(fin[g]), 64'd0);
          check("rst_rden", g, 64'(r0[g]), 64'd0);
          check("rst_addr", g, 64'(addr[g]), 64'd0);
          exp_q[g].delete();
        end
      end
      if (c == 10 && !hold && abort_at < 0) start_rd = 1'b0;
      if (abort_at >= 0) begin
        if (c == abort_at) RESET = 1'b0;
        if (c == abort_at + 1) start_rd = 1'b0;
        if (c == abort_at + 3) begin
          RESET = 1'b1;
          break;
        end
      end
    end
    if (hold) begin
      start_rd = 1'b0;
      repeat (2) @(negedge clk);
      for (int g = 0; g < 4; g++) check("hold_release_fin", g, 64'(fin[g]), 64'd0);
    end
  endtask

  initial begin
    RESET    = 1'b0;
    start_rd = 1'b0;
    mode     = 0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("reset_result", g, 64'(res[g]), 64'd0);
      check("reset_de", g, 64'(de[g]), 64'd0);
      check("reset_fin", g, 64'(fin[g]), 64'd0);
      check("reset_rden", g, 64'(r0[g]), 64'd0);
    end
    RESET = 1'b1;
    @(negedge clk);

    run_strip(0, 1'b0, -1);
    run_strip(1, 1'b0, -1);
    run_strip(2, 1'b0, -1);
    run_strip(3, 1'b0, -1);
    run_strip(1, 1'b0, 15);
    run_strip(3, 1'b0, -1);
    run_strip(3, 1'b1, -1);
    run_strip(3, 1'b0, -1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
